ball_physics: RTL and testbench
===============================

BALL_PHYSICS -- requirements
Module: ball_physics

Interface
REQ-001 The block SHALL have parameters: WIDTH, default 160, map width in tiles; HEIGHT, default 90, map height in tiles; START_X, default 16'd4096, reset x position; START_Y, default 16'd4096, reset y position.
REQ-002 pixel_clk_in  input  1  sole clock; all logic on its rising edge.
REQ-003 rst_in  input  1  synchronous, active-high reset.
REQ-004 new_frame_in  input  1  one-cycle pulse, once per video frame.
REQ-005 shoot_in  input  1  one-cycle shot request.
REQ-006 power_in  input  8  shot strength.
REQ-007 cos_abs_in, sin_abs_in  input  16 each  direction magnitudes, Q8 (256 = 1.0).
REQ-008 cos_sign_in, sin_sign_in  input  1 each  1 = +x / -y, 0 = -x / +y.
REQ-009 tile_addr_out  output  $clog2(WIDTH*HEIGHT)  map tile query address.
REQ-010 tile_data_in  input  4  tile code; valid exactly 2 cycles after tile_addr_out is presented.
REQ-011 ballx_out, bally_out  output  16 each  ball centre, 1/32-pixel units; pixel = [15:5].
REQ-012 moving_out  output  1  ball has nonzero velocity.
REQ-013 in_hole_out  output  1  ball has sunk.
REQ-014 stroke_count_out  output  8  accepted shots, saturates at 255.

Function
REQ-015 Velocity SHALL be held per axis as sign plus 8-bit magnitude; |v| <= 255, below one 8-pixel tile per frame.
REQ-016 Tile codes SHALL be: 0 hole, 2 grass, 3 sand, 1 and 4..15 wall.
REQ-017 FSM states SHALL be IDLE, WAIT_FRAME, QX, WX, UX, QY, WY, UY, FRIC, HOLE.
REQ-018 IDLE: shoot_in SHALL load magnitudes vx = (power_in*cos_abs_in)>>8 and vy = (power_in*sin_abs_in)>>8, each clamped to 255, with signs from cos_sign_in/sin_sign_in.
REQ-019 On an accepted shot, stroke_count_out SHALL increment by 1, saturating at 255.
REQ-020 On an accepted shot, the FSM SHALL move to WAIT_FRAME if either magnitude is nonzero; otherwise it SHALL stay in IDLE, still counting the stroke.
REQ-021 shoot_in SHALL be ignored in every state except IDLE.
REQ-022 WAIT_FRAME: new_frame_in SHALL start one update; new_frame_in arriving in any other state SHALL be ignored.
REQ-023 QX: the block SHALL form candidate cx = x ± vx, 17-bit signed, and drive tile_addr_out = (cx[15:5]>>3) + (y[15:5]>>3)*WIDTH.
REQ-024 In QX, if cx < 0 or cx[15:5] >= WIDTH*8, the candidate SHALL be treated as a wall with no query issued.
REQ-025 UX: wall SHALL mean x unchanged and vx sign inverted; otherwise x = cx.
REQ-026 QY/WY/UY SHALL do the same for y, using the updated x and bound HEIGHT*8.
REQ-027 FRIC SHALL re-query the tile at the final (x, y).
REQ-028 In FRIC, code 0 SHALL set both magnitudes to 0, assert in_hole_out and go to HOLE.
REQ-029 In FRIC, grass SHALL apply m = m - (m>>5) - 1 and sand SHALL apply m = m - (m>>2) - 1 per axis, each saturating at 0.
REQ-030 After FRIC, the FSM SHALL go to IDLE if both magnitudes are 0, else to WAIT_FRAME.
REQ-031 Each update SHALL complete within 16 cycles of new_frame_in.
REQ-032 ballx_out and bally_out SHALL be shadow registers, both committed in the same cycle at the end of FRIC and never mid-update.
REQ-033 moving_out SHALL be 1 exactly when state is not IDLE or HOLE.
REQ-034 HOLE SHALL be exited only by rst_in.

Reset
REQ-035 rst_in SHALL, at any time including mid-update, force state IDLE, x = ballx_out = START_X, y = bally_out = START_Y, magnitudes and signs 0, stroke_count_out 0, in_hole_out 0, moving_out 0 and tile_addr_out 0.

Structure
REQ-036 Tile code constants, the FSM state enum and TILE_LATENCY = 2 SHALL live in a shared package, golf_pkg.
REQ-037 One sub-module, ball_axis_step, SHALL be used: it computes the candidate, bounds check and tile index for one axis and is instantiated per axis.

Verification
REQ-038 Reset: assert rst_in for 1 cycle mid-update -> next cycle ballx_out = 4096, bally_out = 4096, moving_out = 0, stroke_count_out = 0.
REQ-039 Open grass: shoot with power 64, cos_abs 256, cos_sign 1, sin_abs 0, then a frame pulse -> ballx_out = 4160, vx = 61; next frame -> ballx_out = 4221.
REQ-040 Wall: +x shot with vx = 40 where the candidate tile is code 1 -> ballx_out unchanged, next frame x decreases by the post-friction magnitude 38.
REQ-041 Hole: the ball lands on a code-0 tile -> in_hole_out = 1, moving_out = 0; a subsequent shoot_in leaves stroke_count_out unchanged.
REQ-042 Busy: shoot_in while moving -> velocity and stroke_count_out unchanged; new_frame_in during QX..FRIC -> ignored, one update per frame.
REQ-043 Stop: vx = 1 on grass -> magnitude 0 after FRIC, moving_out falls, and the next shoot_in is accepted with stroke_count_out incrementing by 1.

Source files
------------

// File: rtl/golf_pkg.sv
// rtl/golf_pkg.sv - shared tile codes, FSM states and arithmetic helpers for the golf ball
package golf_pkg;

   localparam int TILE_LATENCY = 2;

   localparam logic [3:0] TILE_HOLE  = 4'd0;
   localparam logic [3:0] TILE_GRASS = 4'd2;
   localparam logic [3:0] TILE_SAND  = 4'd3;

   typedef enum logic [3:0] {
      IDLE, WAIT_FRAME, QX, WX, UX, QY, WY, UY, FRIC, HOLE
   } state_t;

   function automatic logic is_wall(input logic [3:0] code);
      return !(code == TILE_HOLE || code == TILE_GRASS || code == TILE_SAND);
   endfunction

   // (power * direction) >> 8, clamped so a velocity never reaches a full tile per frame
   function automatic logic [7:0] shot_mag(input logic [7:0] power, input logic [15:0] dir);
      logic [23:0] prod;
      prod = ({16'd0, power} * {8'd0, dir}) >> 8;
      return (prod > 24'd255) ? 8'hFF : prod[7:0];
   endfunction

   function automatic logic [7:0] apply_friction(input logic [7:0] m, input logic [3:0] code);
      logic [7:0] d;
      case (code)
         TILE_GRASS: d = (m >> 5) + 8'd1;
         TILE_SAND:  d = (m >> 2) + 8'd1;
         default:    d = 8'd0;
      endcase
      return (m > d) ? m - d : 8'd0;
   endfunction

endpackage

// File: rtl/ball_axis_step.sv
// rtl/ball_axis_step.sv - one-axis candidate position, map bounds check and tile coordinate
module ball_axis_step #(
   parameter int LIMIT = 1280
) (
   input  logic [15:0] pos,
   input  logic [7:0]  mag,
   input  logic        add,
   output logic [15:0] cand,
   output logic        blocked,
   output logic [7:0]  tile
);
   localparam logic [11:0] LIM = 12'(LIMIT);

   logic [16:0] sum;

   // bit 16 set means the subtraction went below zero
   assign sum     = add ? ({1'b0, pos} + {9'd0, mag}) : ({1'b0, pos} - {9'd0, mag});
   assign cand    = sum[15:0];
   assign blocked = sum[16] || ({1'b0, sum[15:5]} >= LIM);
   assign tile    = sum[15:8];

endmodule

// File: rtl/ball_physics.sv
// rtl/ball_physics.sv - per-frame golf ball motion with tile collision, friction and hole detection
module ball_physics
   import golf_pkg::*;
#(
   parameter int          WIDTH   = 160,
   parameter int          HEIGHT  = 90,
   parameter logic [15:0] START_X = 16'd4096,
   parameter logic [15:0] START_Y = 16'd4096
) (
   input  logic                            pixel_clk_in,
   input  logic                            rst_in,
   input  logic                            new_frame_in,
   input  logic                            shoot_in,
   input  logic [7:0]                      power_in,
   input  logic [15:0]                     cos_abs_in,
   input  logic [15:0]                     sin_abs_in,
   input  logic                            cos_sign_in,
   input  logic                            sin_sign_in,
   output logic [$clog2(WIDTH*HEIGHT)-1:0] tile_addr_out,
   input  logic [3:0]                      tile_data_in,
   output logic [15:0]                     ballx_out,
   output logic [15:0]                     bally_out,
   output logic                            moving_out,
   output logic                            in_hole_out,
   output logic [7:0]                      stroke_count_out
);
   localparam int         ADDR_W    = $clog2(WIDTH*HEIGHT);
   localparam logic [1:0] WAIT_LAST = 2'(TILE_LATENCY - 1);
   localparam logic [1:0] FRIC_LAST = 2'(TILE_LATENCY + 1);

   state_t      state, state_next;
   logic [15:0] x, y, cand;
   logic [7:0]  vx, vy;
   logic        sx, sy, blocked;
   logic [1:0]  cnt;

   logic [15:0] cx, cy;
   logic        x_blocked, y_blocked;
   logic [7:0]  x_col, y_row;
   logic [7:0]  shot_vx, shot_vy, fric_vx, fric_vy;

   function automatic logic [ADDR_W-1:0] tile_index(input logic [7:0] col, input logic [7:0] row);
      return ADDR_W'(32'(col) + 32'(row) * 32'(WIDTH));
   endfunction

   ball_axis_step #(.LIMIT(WIDTH*8)) x_step (
      .pos(x), .mag(vx), .add(sx), .cand(cx), .blocked(x_blocked), .tile(x_col)
   );

   // sin sign 1 points up the screen, i.e. towards smaller y
   ball_axis_step #(.LIMIT(HEIGHT*8)) y_step (
      .pos(y), .mag(vy), .add(~sy), .cand(cy), .blocked(y_blocked), .tile(y_row)
   );

   assign shot_vx    = shot_mag(power_in, cos_abs_in);
   assign shot_vy    = shot_mag(power_in, sin_abs_in);
   assign fric_vx    = apply_friction(vx, tile_data_in);
   assign fric_vy    = apply_friction(vy, tile_data_in);
   assign moving_out = (state != IDLE) && (state != HOLE);

   always_ff @(posedge pixel_clk_in) begin
      if (rst_in) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:       if (shoot_in && (shot_vx != 8'd0 || shot_vy != 8'd0)) state_next = WAIT_FRAME;
         WAIT_FRAME: if (new_frame_in) state_next = QX;
         QX:         state_next = x_blocked ? UX : WX;
         WX:         if (cnt == WAIT_LAST) state_next = UX;
         UX:         state_next = QY;
         QY:         state_next = y_blocked ? UY : WY;
         WY:         if (cnt == WAIT_LAST) state_next = UY;
         UY:         state_next = FRIC;
         FRIC: begin
            if (cnt == FRIC_LAST) begin
               if (tile_data_in == TILE_HOLE)                   state_next = HOLE;
               else if (fric_vx == 8'd0 && fric_vy == 8'd0)     state_next = IDLE;
               else                                             state_next = WAIT_FRAME;
            end
         end
         HOLE:       state_next = HOLE;
         default:    state_next = IDLE;
      endcase
   end

   always_ff @(posedge pixel_clk_in) begin
      if (rst_in) begin
         x                <= START_X;
         y                <= START_Y;
         ballx_out        <= START_X;
         bally_out        <= START_Y;
         vx               <= 8'd0;
         vy               <= 8'd0;
         sx               <= 1'b0;
         sy               <= 1'b0;
         cand             <= 16'd0;
         blocked          <= 1'b0;
         cnt              <= 2'd0;
         stroke_count_out <= 8'd0;
         in_hole_out      <= 1'b0;
         tile_addr_out    <= '0;
      end else begin
         cnt <= (state_next != state) ? 2'd0 : cnt + 1'b1;
         case (state)
            IDLE: begin
               if (shoot_in) begin
                  vx <= shot_vx;
                  vy <= shot_vy;
                  sx <= cos_sign_in;
                  sy <= sin_sign_in;
                  if (stroke_count_out != 8'hFF) stroke_count_out <= stroke_count_out + 8'd1;
               end
            end
            QX: begin
               cand    <= cx;
               blocked <= x_blocked;
               if (!x_blocked) tile_addr_out <= tile_index(x_col, y[15:8]);
            end
            UX: begin
               if (blocked || is_wall(tile_data_in)) sx <= ~sx;
               else                                  x  <= cand;
            end
            QY: begin
               cand    <= cy;
               blocked <= y_blocked;
               if (!y_blocked) tile_addr_out <= tile_index(x[15:8], y_row);
            end
            UY: begin
               if (blocked || is_wall(tile_data_in)) sy <= ~sy;
               else                                  y  <= cand;
            end
            FRIC: begin
               if (cnt == 2'd0) begin
                  tile_addr_out <= tile_index(x[15:8], y[15:8]);
               end else if (cnt == FRIC_LAST) begin
                  ballx_out <= x;
                  bally_out <= y;
                  if (tile_data_in == TILE_HOLE) begin
                     vx          <= 8'd0;
                     vy          <= 8'd0;
                     in_hole_out <= 1'b1;
                  end else begin
                     vx <= fric_vx;
                     vy <= fric_vy;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ball_physics.sv
// tb/tb_ball_physics.sv - scoreboard bench for ball_physics against a behavioural ball model
module tb_ball_physics;

   logic        clk = 1'b0;
   logic        rst_in, new_frame_in, shoot_in, cos_sign_in, sin_sign_in;
   logic [7:0]  power_in;
   logic [15:0] cos_abs_in, sin_abs_in;
   logic [13:0] tile_addr_out;
   logic [3:0]  tile_data_in, d1;
   logic [15:0] ballx_out, bally_out;
   logic        moving_out, in_hole_out;
   logic [7:0]  stroke_count_out;

   always #5 clk = ~clk;

   ball_physics dut (
      .pixel_clk_in(clk), .rst_in(rst_in), .new_frame_in(new_frame_in), .shoot_in(shoot_in),
      .power_in(power_in), .cos_abs_in(cos_abs_in), .sin_abs_in(sin_abs_in),
      .cos_sign_in(cos_sign_in), .sin_sign_in(sin_sign_in), .tile_addr_out(tile_addr_out),
      .tile_data_in(tile_data_in), .ballx_out(ballx_out), .bally_out(bally_out),
      .moving_out(moving_out), .in_hole_out(in_hole_out), .stroke_count_out(stroke_count_out)
   );

   // tile map with two cycles of read latency
   logic [3:0] map_mem [0:16383];
   always @(posedge clk) begin
      d1           <= map_mem[tile_addr_out];
      tile_data_in <= d1;
   end

   typedef struct {
      int x; int y; int moving; int hole; int stroke;
   } snap_t;
   snap_t sb[$];

   int n_tests = 0, n_fail = 0;
   int m_x, m_y, m_vx, m_vy, m_stroke;
   bit m_sx, m_sy, m_moving, m_hole;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int tile_at(input int col, input int row);
      return int'(map_mem[col + row * 160]);
   endfunction

   function automatic bit wall_code(input int code);
      return !(code == 0 || code == 2 || code == 3);
   endfunction

   function automatic int fric(input int m, input int code);
      int r;
      if (code == 2)      r = m - m / 32 - 1;
      else if (code == 3) r = m - m / 4 - 1;
      else                r = m;
      return (r < 0) ? 0 : r;
   endfunction

   task automatic fill_map(input int code);
      for (int i = 0; i < 16384; i++) map_mem[i] = 4'(code);
   endtask

   task automatic model_reset();
      m_x = 4096; m_y = 4096; m_vx = 0; m_vy = 0; m_sx = 0; m_sy = 0;
      m_stroke = 0; m_moving = 0; m_hole = 0;
   endtask

   task automatic model_shot(input int p, input int c, input int cs, input int s, input int ss);
      if (!m_moving && !m_hole) begin
         m_vx = (p * c) >> 8; if (m_vx > 255) m_vx = 255;
         m_vy = (p * s) >> 8; if (m_vy > 255) m_vy = 255;
         m_sx = cs[0]; m_sy = ss[0];
         if (m_stroke < 255) m_stroke++;
         m_moving = (m_vx != 0) || (m_vy != 0);
      end
   endtask

   task automatic model_frame();
      int  cx, cy, code;
      bit  wall;
      if (!m_moving) return;
      cx = m_sx ? m_x + m_vx : m_x - m_vx;
      if (cx < 0 || cx / 32 >= 1280) wall = 1;
      else                           wall = wall_code(tile_at(cx / 256, m_y / 256));
      if (wall) m_sx = !m_sx; else m_x = cx;
      cy = m_sy ? m_y - m_vy : m_y + m_vy;
      if (cy < 0 || cy / 32 >= 720) wall = 1;
      else                          wall = wall_code(tile_at(m_x / 256, cy / 256));
      if (wall) m_sy = !m_sy; else m_y = cy;
      code = tile_at(m_x / 256, m_y / 256);
      if (code == 0) begin
         m_vx = 0; m_vy = 0; m_hole = 1; m_moving = 0;
      end else begin
         m_vx = fric(m_vx, code); m_vy = fric(m_vy, code);
         m_moving = (m_vx != 0) || (m_vy != 0);
      end
   endtask

   task automatic push_expect();
      snap_t e;
      e.x = m_x; e.y = m_y; e.moving = int'(m_moving); e.hole = int'(m_hole); e.stroke = m_stroke;
      sb.push_back(e);
   endtask

   task automatic pop_compare(input string tag);
      snap_t e;
      check({tag, " queue"}, sb.size(), 1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      check({tag, " x"}, 32'(ballx_out), e.x);
      check({tag, " y"}, 32'(bally_out), e.y);
      check({tag, " moving"}, 32'(moving_out), e.moving);
      check({tag, " in_hole"}, 32'(in_hole_out), e.hole);
      check({tag, " strokes"}, 32'(stroke_count_out), e.stroke);
   endtask

   task automatic do_reset();
      @(negedge clk); rst_in = 1;
      @(negedge clk); rst_in = 0;
      model_reset();
   endtask

   task automatic shoot(input int p, input int c, input int cs, input int s, input int ss);
      @(negedge clk);
      power_in = 8'(p); cos_abs_in = 16'(c); cos_sign_in = cs[0];
      sin_abs_in = 16'(s); sin_sign_in = ss[0]; shoot_in = 1;
      @(negedge clk); shoot_in = 0;
      model_shot(p, c, cs, s, ss);
      push_expect();
      pop_compare("shot");
   endtask

   // extra: hammer new_frame_in and shoot_in while the update is in flight
   task automatic frame(input bit extra);
      int old_x;
      bit busy;
      old_x = m_x;
      busy  = extra && m_moving;
      model_frame();
      push_expect();
      @(negedge clk); new_frame_in = 1;
      @(negedge clk); new_frame_in = 0;
      for (int k = 0; k < 16; k++) begin
         if (busy && k == 2) begin
            new_frame_in = 1; shoot_in = 1; power_in = 8'd200; cos_abs_in = 16'd256;
         end
         if (k == 3) begin
            new_frame_in = 0; shoot_in = 0;
         end
         if (k == 6) check("shadow_hold", 32'(ballx_out), old_x);
         @(negedge clk);
      end
      pop_compare("frame");
   endtask

   task automatic run_until_stop(input int max_frames);
      for (int i = 0; i < max_frames && m_moving; i++) frame(i % 4 == 1);
      check("stopped", 32'(moving_out), 32'(m_moving));
   endtask

   initial begin
      rst_in = 1; new_frame_in = 0; shoot_in = 0; power_in = 0;
      cos_abs_in = 0; sin_abs_in = 0; cos_sign_in = 0; sin_sign_in = 0;
      fill_map(2);
      repeat (3) @(negedge clk);
      rst_in = 0;
      model_reset();
      check("rst ballx", 32'(ballx_out), 4096);
      check("rst bally", 32'(bally_out), 4096);
      check("rst moving", 32'(moving_out), 0);
      check("rst strokes", 32'(stroke_count_out), 0);
      check("rst in_hole", 32'(in_hole_out), 0);
      check("rst tile_addr", 32'(tile_addr_out), 0);

      // open grass, +x
      shoot(64, 256, 1, 0, 0);
      frame(0);
      check("grass_x1", 32'(ballx_out), 4160);
      frame(0);
      check("grass_x2", 32'(ballx_out), 4221);
      run_until_stop(200);

      // sand patch
      do_reset();
      for (int r = 14; r <= 18; r++)
         for (int c = 14; c <= 30; c++) map_mem[c + r * 160] = 4'd3;
      shoot(200, 256, 1, 0, 0);
      run_until_stop(100);

      // straight up into the top map edge
      do_reset();
      fill_map(2);
      shoot(255, 0, 0, 256, 1);
      run_until_stop(200);

      // wall tile immediately to the left
      do_reset();
      map_mem[15 + 16 * 160] = 4'd1;
      shoot(40, 256, 0, 0, 0);
      frame(0);
      check("wall_hold", 32'(ballx_out), 4096);
      frame(0);
      check("wall_bounce", 32'(ballx_out), 4096 + 38);
      run_until_stop(100);
      map_mem[15 + 16 * 160] = 4'd2;

      // slowest possible roll stops after one frame, next shot accepted
      do_reset();
      shoot(1, 256, 1, 0, 0);
      frame(0);
      check("stop_x", 32'(ballx_out), 4097);
      check("stop_moving", 32'(moving_out), 0);
      shoot(10, 256, 1, 0, 0);
      check("stop_reshoot", 32'(stroke_count_out), 2);
      run_until_stop(50);

      // zero-strength shots count strokes and saturate
      do_reset();
      for (int i = 0; i < 258; i++) shoot(0, 256, 1, 0, 0);
      check("stroke_sat", 32'(stroke_count_out), 255);

      // hole under the ball
      do_reset();
      map_mem[16 + 16 * 160] = 4'd0;
      shoot(10, 256, 1, 0, 0);
      frame(0);
      check("hole_flag", 32'(in_hole_out), 1);
      check("hole_moving", 32'(moving_out), 0);
      shoot(50, 256, 1, 0, 0);
      check("hole_strokes", 32'(stroke_count_out), 1);
      frame(0);
      do_reset();
      check("hole_cleared", 32'(in_hole_out), 0);
      map_mem[16 + 16 * 160] = 4'd2;

      // reset in the middle of an update
      shoot(100, 256, 1, 0, 0);
      @(negedge clk); new_frame_in = 1;
      @(negedge clk); new_frame_in = 0;
      repeat (5) @(negedge clk);
      rst_in = 1;
      @(negedge clk); rst_in = 0;
      model_reset();
      check("midrst ballx", 32'(ballx_out), 4096);
      check("midrst bally", 32'(bally_out), 4096);
      check("midrst moving", 32'(moving_out), 0);
      check("midrst strokes", 32'(stroke_count_out), 0);
      check("midrst tile_addr", 32'(tile_addr_out), 0);
      repeat (20) @(negedge clk);
      check("midrst settled", 32'(ballx_out), 4096);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
